// File: rtl/decoder_pkg.sv
// decoder_pkg: shared mode encoding and one-hot helper for the decoder blocks
package decoder_pkg;
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } scan_mode_e;
  localparam int MAX_N = 256;
  function automatic logic [MAX_N-1:0] onehot_f(input int unsigned index, input logic polarity);
    logic [MAX_N-1:0] v;
    v = MAX_N'(1) << index;
    return polarity ? ~v : v;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: counts enabled scan clocks and flags the last clock of each step
module tick_divider #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int DIV_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [DIV_W-1:0] div_q, div_d;
  assign tick = run && div_q == DIV_W'(TICK_DIV - 1);
  always_comb begin
    div_d = div_q;
    if (clr || tick) div_d = '0;
    else if (run) div_d = div_q + 1'b1;
  end
  always_ff @(posedge clk) div_q <= rst ? '0 : div_d;
endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with direct and scan modes
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int TICK_DIV   = 100000,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int N         = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot,
  output logic [SEL_W-1:0] idx,
  output logic             step
);
  logic             scan, tick;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             step_q, step_d;
  logic [N-1:0]     out_q, out_d;
  assign scan = scan_mode_e'(mode) == MODE_SCAN;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .run (en && scan),
    .clr (en && !scan),
    .tick(tick)
  );
  always_comb begin
    idx_d  = idx_q;
    step_d = 1'b0;
    out_d  = {N{ACTIVE_LOW}};
    if (en) begin
      idx_d  = scan ? (tick ? idx_q + 1'b1 : idx_q) : sel;
      step_d = tick;
      out_d  = N'(onehot_f(int'(idx_d), ACTIVE_LOW));
    end
  end
  always_ff @(posedge clk) begin
    idx_q  <= rst ? '0 : idx_d;
    step_q <= rst ? 1'b0 : step_d;
    out_q  <= rst ? {N{ACTIVE_LOW}} : out_d;
  end
  assign onehot = out_q;
  assign idx    = idx_q;
  assign step   = step_q;
endmodule
